math_adder_8bit: RTL and testbench
==================================

// Module: math_adder_8bit
// PURPOSE
//   Registered 8-bit unsigned adder with carry-in, used as the ADD datapath of the
//   FSM calculator. Computes a + b + cin as a full 9-bit result (bit 8 = carry-out).
//   Operands are sampled every clock. The result appears on sum one cycle later.
// PARAMETERS
//   WIDTH  8  operand width; sum is WIDTH+1 bits (only 8 is verified)
// PORTS
//   clk    in   1  single system clock; all state updates on rising edge
//   rst_n  in   1  synchronous reset, active-low, sampled on rising clk edge
//   a      in   8  unsigned operand A
//   b      in   8  unsigned operand B
//   cin    in   1  carry-in, weight 1
//   sum    out  9  registered result {cout, sum[7:0]} = a + b + cin
// BEHAVIOUR
//   - Reset: rst_n=0 at a rising clk edge -> sum <= 9'd0. Reset has priority over
//     new operands. No asynchronous path.
//   - Normal: every rising edge with rst_n=1, sum <= a + b + cin, zero-extended to 9 bits.
//   - Latency: exactly 1 clock. Throughput is 1 result per clock; there is no handshake.
//   - Width: result range 0..511 (max 255+255+1 = 511 = 9'h1FF). No overflow or
//     wrap is possible. Bit 8 is the true carry-out.
//   - Inputs are not registered separately. They must be stable around the rising
//     edge (single clock domain).
//   - Reset mid-stream: the result in flight is discarded. The first valid sum is
//     the cycle after rst_n returns high.
//   - sum holds its value whenever inputs are unchanged.
//   - No X propagation from reset: sum is defined from the first reset edge.
// STRUCTURE
//   - Shared package math_pkg: localparam ADD_W = 8, typedef logic [ADD_W:0] add_res_t.
//   - Sub-module math_full_adder (a, b, cin -> s, cout) is instantiated WIDTH times
//     in a generate loop to form the ripple-carry chain:
//       c[0] = cin
//       c[i+1] = cout of bit i
//       the next-state value is {c[WIDTH], s}
//   - A single output register stage in math_adder_8bit holds sum.
// TESTING
//   1) rst_n=0 for 2 clocks with a=8'hFF, b=8'hFF, cin=1 -> sum=9'h000.
//   2) a=8'h01, b=8'h01, cin=0 -> sum=9'h002 one clock later.
//   3) a=8'hFF, b=8'h01, cin=0 -> sum=9'h100 (carry-out set).
//   4) a=8'hAA, b=8'h55, cin=1 -> sum=9'h100.
//   5) a=8'h0F, b=8'hF0, cin=0 -> sum=9'h0FF.
//   6) a=8'h80, b=8'h80, cin=1 -> sum=9'h101.
//      Then assert rst_n=0 for 1 clock -> sum=9'h000.
//      Then release -> the next edge loads the new result.
//   - Also: random a/b/cin over 1000 cycles, checked against the 1-cycle-delayed
//     reference a+b+cin.

Source files
------------

// File: rtl/math_adder_8bit_pkg.sv
// ============================================================================
// Module  : math_pkg
// Brief   : Shared widths and result type for the calculator math datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package math_pkg;

    localparam int ADD_W = 8;

    typedef logic [ADD_W:0] add_res_t;

endpackage : math_pkg

`default_nettype wire

// File: rtl/math_adder_8bit_if.sv
// ============================================================================
// Module  : math_adder_8bit_if
// Brief   : Operand/result bundle of the registered adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface math_adder_8bit_if
    import math_pkg::*;
#(
    parameter int WIDTH = ADD_W
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   sum;

    modport master (
        output a,
        output b,
        output cin,
        input  sum
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum
    );

endinterface : math_adder_8bit_if

`default_nettype wire

// File: rtl/math_adder_8bit_full_adder.sv
// ============================================================================
// Module  : math_full_adder
// Brief   : One-bit full adder cell of the ripple-carry chain.
// Revision: 1.0
// ============================================================================
`default_nettype none

module math_full_adder (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic cin_i,
    output logic      s_o,
    output logic      cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule : math_full_adder

`default_nettype wire

// File: rtl/math_adder_8bit.sv
// ============================================================================
// Module  : math_adder_8bit
// Brief   : Registered unsigned adder, sum = a + b + cin with 1-cycle latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module math_adder_8bit
    import math_pkg::*;
#(
    parameter int WIDTH = ADD_W
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    math_adder_8bit_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] bit_sum;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH:0]   sum_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        math_full_adder u_fa (
            .a_i    (bus.a[i]),
            .b_i    (bus.b[i]),
            .cin_i  (carry[i]),
            .s_o    (bit_sum[i]),
            .cout_o (carry[i+1])
        );
    end

    // Top carry becomes bit WIDTH, so the result never wraps.
    assign sum_d = {carry[WIDTH], bit_sum};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.sum = sum_q;

endmodule : math_adder_8bit

`default_nettype wire

// File: tb/tb_math_adder_8bit.sv
// ============================================================================
// Module  : tb_math_adder_8bit
// Brief   : Directed-vector and randomised bench for the registered adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_math_adder_8bit;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    math_adder_8bit_if #(.WIDTH(8)) bus ();

    math_adder_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] exp);
        n_cmp++;
        if (bus.sum !== exp) begin
            n_err++;
            $display("FAIL %s: got 9'h%03h, required 9'h%03h", name, bus.sum, exp);
        end
    endtask

    // Drive at the falling edge, then sample 1 time unit after the next rise.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic rn);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        rst_n   = rn;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [5];

    initial begin
        logic [8:0] exp;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{8'h01, 8'h01, 1'b0, 9'h002};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[2] = '{8'hAA, 8'h55, 1'b1, 9'h100};
        vecs[3] = '{8'h0F, 8'hF0, 1'b0, 9'h0FF};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 9'h101};

        rst_n   = 1'b0;
        bus.a   = 8'hFF;
        bus.b   = 8'hFF;
        bus.cin = 1'b1;

        // Reset wins over maximal operands.
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("reset_1", 9'h000);
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        check("reset_2", 9'h000);

        for (int i = 0; i < 5; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
            check($sformatf("vec_%0d", i), vecs[i].exp);
        end

        // Unchanged inputs keep the result steady.
        step(8'h80, 8'h80, 1'b1, 1'b1);
        check("hold", 9'h101);

        // Mid-stream reset discards the in-flight result.
        step(8'h12, 8'h34, 1'b0, 1'b0);
        check("mid_reset", 9'h000);
        step(8'h12, 8'h34, 1'b0, 1'b1);
        check("after_release", 9'h046);

        step(8'hFF, 8'hFF, 1'b1, 1'b1);
        check("max", 9'h1FF);
        step(8'h00, 8'h00, 1'b0, 1'b1);
        check("zero", 9'h000);
        step(8'h00, 8'h00, 1'b1, 1'b1);
        check("cin_only", 9'h001);
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        check("cin_ripple", 9'h100);

        for (int k = 0; k < 1000; k++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rc  = 1'($urandom_range(0, 1));
            exp = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            step(ra, rb, rc, 1'b1);
            check("random", exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_math_adder_8bit

`default_nettype wire
